// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator display path.
package calc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ENTRY  = 2'b01,
    ST_ERROR  = 2'b10,
    ST_RESULT = 2'b11
  } status_e;

  typedef logic [6:0] seg7_t;

  localparam seg7_t      SEG_BLANK  = 7'h00;
  localparam int         NUM_DIGITS = 8;
  localparam logic [6:0] SEG_N_OFF  = 7'h7F;
  localparam logic [7:0] AN_N_OFF   = 8'hFF;

  // Active-low one-hot anode select for a digit index.
  function automatic logic [7:0] an_sel_n(input logic [2:0] idx);
    return ~(8'b1 << idx);
  endfunction

endpackage

// File: rtl/calc_display_tick.sv
// Digit-slot prescaler: cnt runs 0..CLK_DIV-1, tick on the last cycle of a slot,
// blank while cnt is inside the anti-ghosting window at the start of the slot.
module calc_display_tick #(
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  output logic tick,
  output logic blank
);

  logic [15:0] cnt;

  if (CLK_DIV < 2 || CLK_DIV > 65535 || BLANK_CYCLES >= CLK_DIV) begin : g_bad_cfg
    $error("calc_display_tick: CLK_DIV must be 2..65535 and BLANK_CYCLES < CLK_DIV");
  end

  assign tick  = (cnt == 16'(CLK_DIV - 1));
  assign blank = (cnt < 16'(BLANK_CYCLES));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 16'd1;
  end

endmodule

// File: rtl/calc_display_scan.sv
// 8-digit common-anode scanner with per-frame snapshot and blank slots.
// Optional ERROR_BLINK_EN: blink the whole display while the snapshotted status is error.
module calc_display_scan
  import calc_pkg::*;
#(
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] displays [7:0],
  input  logic [1:0] status,
  output logic [6:0] seg_n,
  output logic [7:0] an_n,
  output logic       frame_start,
  output logic [1:0] status_led
);

  if (BLINK_FRAMES < 1) begin : g_bad_cfg
    $error("calc_display_scan: BLINK_FRAMES must be >= 1");
  end

  logic       tick, blank, snap, hide, primed;
  logic [2:0] idx;
  status_e    status_q;
  seg7_t      shadow [NUM_DIGITS];
  logic [6:0] seg_nx;
  logic [7:0] an_nx;

  calc_display_tick #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick),
    .blank (blank)
  );

  // Leaving slot 7 starts a new frame: take the snapshot on that edge.
  assign snap = tick && (idx == 3'd7);

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_shadow
    always_ff @(posedge clock or posedge reset) begin
      if (reset)     shadow[i] <= SEG_BLANK;
      else if (snap) shadow[i] <= displays[i];
    end
  end

  // primed keeps the anodes off until the first real snapshot exists.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      primed      <= 1'b0;
      status_q    <= ST_IDLE;
      frame_start <= 1'b0;
    end else begin
      frame_start <= snap;
      if (tick) idx <= idx + 3'd1;
      if (snap) begin
        status_q <= status_e'(status);
        primed   <= 1'b1;
      end
    end
  end

  assign status_led = status_q;

`ifdef ERROR_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] fcnt;
  logic          phase_on;

  // Frames are counted as they end, so the first error frame is always lit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fcnt     <= '0;
      phase_on <= 1'b1;
    end else if (snap) begin
      if (status != ST_ERROR || status_q != ST_ERROR) begin
        fcnt     <= '0;
        phase_on <= 1'b1;
      end else if (fcnt == FW'(BLINK_FRAMES - 1)) begin
        fcnt     <= '0;
        phase_on <= ~phase_on;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign hide = (status_q == ST_ERROR) && !phase_on;
`else
  assign hide = 1'b0;
`endif

  always_comb begin
    an_nx  = AN_N_OFF;
    seg_nx = SEG_N_OFF;
    if (primed && !blank && !hide) begin
      an_nx  = an_sel_n(idx);
      seg_nx = ~shadow[idx];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an_n  <= AN_N_OFF;
      seg_n <= SEG_N_OFF;
    end else begin
      an_n  <= an_nx;
      seg_n <= seg_nx;
    end
  end

endmodule

// File: tb/tb_calc_display_scan.sv
// Scoreboard bench for calc_display_scan (CLK_DIV=4, BLANK_CYCLES=1, BLINK_FRAMES=2).
module tb_calc_display_scan;
  localparam int CD = 4;
  localparam int BC = 1;
  localparam int BF = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] displays [7:0];
  logic [1:0] status;
  logic [6:0] seg_n;
  logic [7:0] an_n;
  logic       frame_start;
  logic [1:0] status_led;

  calc_display_scan #(.CLK_DIV(CD), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF)) dut (
    .clock       (clock),
    .reset       (reset),
    .displays    (displays),
    .status      (status),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .frame_start (frame_start),
    .status_led  (status_led)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         ep;
    int         e;
    bit         do_an;
    logic [7:0] an;
    logic [6:0] seg;
    bit         do_fl;
    logic       fs;
    logic [1:0] led;
    string      nm;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   e = 0;     // posedges since the last reset release
  int   ep = 0;    // reset-release epoch
  bit   done = 0;

  function automatic void push(int pep, int pe, bit da, logic [7:0] a, logic [6:0] s,
                               bit df, logic f, logic [1:0] l, string nm);
    exp_t x;
    x.ep = pep; x.e = pe; x.do_an = da; x.an = a; x.seg = s;
    x.do_fl = df; x.fs = f; x.led = l; x.nm = nm;
    sbq.push_back(x);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (epoch %0d cycle %0d)", nm, got, exp, ep, e);
    end
  endtask

  task automatic wait_e(input int t);
    while (e < t) @(negedge clock);
  endtask

  initial forever begin
    @(posedge clock);
    e = reset ? 0 : e + 1;
  end

  // Monitor: pops expectations due this cycle plus per-cycle invariants.
  initial begin
    int         last_dig;
    int         dig;
    logic [7:0] prev_an;
    exp_t       x;
    last_dig = 7;
    prev_an  = 8'hFF;
    forever begin
      @(negedge clock);
      while (sbq.size() > 0 && (sbq[0].ep < ep || (sbq[0].ep == ep && sbq[0].e < e))) begin
        x = sbq.pop_front();
        chk({x.nm, "_missed"}, 0, 1);
      end
      while (sbq.size() > 0 && sbq[0].ep == ep && sbq[0].e == e) begin
        x = sbq.pop_front();
        if (x.do_an) begin
          chk({x.nm, ".an_n"}, an_n, x.an);
          chk({x.nm, ".seg_n"}, seg_n, x.seg);
        end
        if (x.do_fl) begin
          chk({x.nm, ".frame_start"}, frame_start, x.fs);
          chk({x.nm, ".status_led"}, status_led, x.led);
        end
      end
      if (done && sbq.size() > 0) begin
        x = sbq.pop_front();
        chk({x.nm, "_unreached"}, 0, 1);
      end
      chk("an_n_onehot", ($countones(~an_n) <= 1), 1);
      if (!reset && ep >= 1) chk("frame_start_period", frame_start, (e > 0 && e % 32 == 0));
      if (reset) begin
        last_dig = 7;
      end else if (an_n != 8'hFF && an_n != prev_an) begin
        dig = 0;
        for (int i = 0; i < 8; i++) if (!an_n[i]) dig = i;
        chk("idx_order", dig, (last_dig + 1) % 8);
        last_dig = dig;
      end
      prev_an = an_n;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end (epoch %0d cycle %0d)", ep, e);
    $fatal(1);
  end

  initial begin
    status = 2'b01;
    for (int i = 0; i < 8; i++) displays[i] = (i == 0) ? 7'h06 : 7'h3F;

    // Epoch 0: held in reset
    push(0, 0, 1, 8'hFF, 7'h7F, 1, 1'b0, 2'b00, "reset_state");
    // Epoch 1: blank until the first snapshot, frame_start exactly at edge 32
    for (int k = 1; k <= 33; k++)
      push(1, k, 1, 8'hFF, 7'h7F, 1, (k == 32), (k >= 32) ? 2'b01 : 2'b00, "prescan");
    push(1, 34, 1, 8'hFE, 7'h79, 0, 0, 0, "slot0_a");
    push(1, 35, 1, 8'hFE, 7'h79, 0, 0, 0, "slot0_b");
    push(1, 36, 1, 8'hFE, 7'h79, 0, 0, 0, "slot0_c");
    push(1, 37, 1, 8'hFF, 7'h7F, 0, 0, 0, "slot1_blank");
    push(1, 42, 1, 8'hFB, 7'h40, 0, 0, 0, "slot2_old");
    push(1, 45, 1, 8'hFF, 7'h7F, 0, 0, 0, "slot3_blank");
    push(1, 46, 1, 8'hF7, 7'h40, 0, 0, 0, "slot3_a");
    push(1, 47, 1, 8'hF7, 7'h40, 0, 0, 0, "slot3_b");
    push(1, 48, 1, 8'hF7, 7'h40, 0, 0, 0, "slot3_c");
    push(1, 64, 0, 0, 0, 1, 1'b1, 2'b01, "frame2_start");
    push(1, 74, 1, 8'hFB, 7'h24, 0, 0, 0, "slot2_new");
    push(1, 95, 0, 0, 0, 1, 1'b0, 2'b01, "led_hold");
    push(1, 96, 0, 0, 0, 1, 1'b1, 2'b11, "led_update");
    push(1, 116, 1, 8'hEF, 7'h40, 0, 0, 0, "pre_reset_lit");
    push(1, 118, 1, 8'hFF, 7'h7F, 1, 1'b0, 2'b00, "reset_midslot");
    // Epoch 2: restart after mid-slot reset
    for (int k = 1; k <= 33; k++)
      push(2, k, 1, 8'hFF, 7'h7F, 1, (k == 32), (k >= 32) ? 2'b11 : 2'b00, "restart");
    push(2, 34, 1, 8'hFE, 7'h79, 0, 0, 0, "rs_slot0_a");
    push(2, 36, 1, 8'hFE, 7'h79, 0, 0, 0, "rs_slot0_c");
    push(2, 37, 1, 8'hFF, 7'h7F, 0, 0, 0, "rs_slot1_blank");
    push(2, 38, 1, 8'hFD, 7'h40, 0, 0, 0, "rs_slot1");
    push(2, 42, 1, 8'hFB, 7'h24, 0, 0, 0, "rs_slot2");
    push(2, 3264, 0, 0, 0, 1, 1'b1, 2'b10, "err_snap");
    push(2, 3266, 1, 8'hFE, 7'h79, 0, 0, 0, "err_f1_lit");
    push(2, 3298, 1, 8'hFE, 7'h79, 0, 0, 0, "err_f2_lit");
`ifdef ERROR_BLINK_EN
    push(2, 3330, 1, 8'hFF, 7'h7F, 0, 0, 0, "err_f3_off");
    push(2, 3340, 1, 8'hFF, 7'h7F, 0, 0, 0, "err_f3_off_b");
`else
    push(2, 3330, 1, 8'hFE, 7'h79, 0, 0, 0, "err_f3_noblink");
    push(2, 3340, 1, 8'hFB, 7'h24, 0, 0, 0, "err_f3_noblink_b");
`endif
    push(2, 3360, 0, 0, 0, 1, 1'b1, 2'b01, "recover_snap");
    push(2, 3362, 1, 8'hFE, 7'h79, 0, 0, 0, "recover_lit");

    repeat (3) @(negedge clock);
    reset = 1'b0;
    ep    = 1;

    wait_e(38);                 // idx=1: slot 2 of this frame must keep the old pattern
    displays[2] = 7'h5B;
    wait_e(70);
    status = 2'b11;
    wait_e(117);                // after edge 118 the scanner sits at idx=5, cnt=2
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    ep    = 2;

    wait_e(3237);               // 101 frames of scanning checked by the invariants
    status = 2'b10;
    wait_e(3335);               // inside the third error frame
    status = 2'b01;
    wait_e(3370);
    done = 1;
    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
